// File: rtl/forwarding_ctrl.sv
// Forwarding select and load-use hazard detection for a 5-stage pipeline, tracking EX/MEM/WB shadows.
// Latency: forwarding selects and load-use stall are combinational (0 cycles); shadows advance one stage per clock.
// Backpressure: mem_stall_i freezes all state; a load-use stall injects an EX bubble and counts the cycle.
module forwarding_ctrl #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [REG_W-1:0] id_rs1_i,
   input  logic [REG_W-1:0] id_rs2_i,
   input  logic [REG_W-1:0] id_rd_i,
   input  logic             id_regwrite_i,
   input  logic             id_memread_i,
   input  logic             flush_i,
   input  logic             mem_stall_i,
   output logic [1:0]       fwd_a_o,
   output logic [1:0]       fwd_b_o,
   output logic             ld_use_stall_o,
   output logic [CNT_W-1:0] ld_use_cnt_o
);

   // EX stage shadow
   logic [REG_W-1:0] ex_rs1_q, ex_rs1_d;
   logic [REG_W-1:0] ex_rs2_q, ex_rs2_d;
   logic [REG_W-1:0] ex_rd_q,  ex_rd_d;
   logic             ex_regwrite_q, ex_regwrite_d;
   logic             ex_memread_q,  ex_memread_d;
   // MEM stage shadow
   logic [REG_W-1:0] mem_rd_q, mem_rd_d;
   logic             mem_regwrite_q, mem_regwrite_d;
   // WB stage shadow
   logic [REG_W-1:0] wb_rd_q, wb_rd_d;
   logic             wb_regwrite_q, wb_regwrite_d;
   // Load-use stall counter
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic ld_use_stall;

   // A load in EX whose rd feeds the instruction in ID cannot be forwarded in time
   always_comb begin
      ld_use_stall = ex_memread_q && (ex_rd_q != '0) &&
                     ((ex_rd_q == id_rs1_i) || (ex_rd_q == id_rs2_i));
   end

   // Operand selects: newer result in EX/MEM beats older one in MEM/WB; x0 never forwards
   always_comb begin
      fwd_a_o = 2'b00;
      fwd_b_o = 2'b00;
      if (mem_regwrite_q && (mem_rd_q != '0) && (mem_rd_q == ex_rs1_q)) begin
         fwd_a_o = 2'b10;
      end else if (wb_regwrite_q && (wb_rd_q != '0) && (wb_rd_q == ex_rs1_q)) begin
         fwd_a_o = 2'b01;
      end
      if (mem_regwrite_q && (mem_rd_q != '0) && (mem_rd_q == ex_rs2_q)) begin
         fwd_b_o = 2'b10;
      end else if (wb_regwrite_q && (wb_rd_q != '0) && (wb_rd_q == ex_rs2_q)) begin
         fwd_b_o = 2'b01;
      end
   end

   // Next-state: freeze dominates, then stall/flush bubble, else advance ID into EX
   always_comb begin
      ex_rs1_d       = ex_rs1_q;
      ex_rs2_d       = ex_rs2_q;
      ex_rd_d        = ex_rd_q;
      ex_regwrite_d  = ex_regwrite_q;
      ex_memread_d   = ex_memread_q;
      mem_rd_d       = mem_rd_q;
      mem_regwrite_d = mem_regwrite_q;
      wb_rd_d        = wb_rd_q;
      wb_regwrite_d  = wb_regwrite_q;
      cnt_d          = cnt_q;
      if (!mem_stall_i) begin
         wb_rd_d        = mem_rd_q;
         wb_regwrite_d  = mem_regwrite_q;
         mem_rd_d       = ex_rd_q;
         mem_regwrite_d = ex_regwrite_q;
         if (ld_use_stall || flush_i) begin
            // Bubble: fields zeroed so it can neither write nor match anything
            ex_rs1_d      = '0;
            ex_rs2_d      = '0;
            ex_rd_d       = '0;
            ex_regwrite_d = 1'b0;
            ex_memread_d  = 1'b0;
         end else begin
            ex_rs1_d      = id_rs1_i;
            ex_rs2_d      = id_rs2_i;
            ex_rd_d       = id_rd_i;
            ex_regwrite_d = id_regwrite_i;
            ex_memread_d  = id_memread_i;
         end
         if (ld_use_stall && !(&cnt_q)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // Shadow and counter registers, cleared asynchronously
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ex_rs1_q       <= '0;
         ex_rs2_q       <= '0;
         ex_rd_q        <= '0;
         ex_regwrite_q  <= 1'b0;
         ex_memread_q   <= 1'b0;
         mem_rd_q       <= '0;
         mem_regwrite_q <= 1'b0;
         wb_rd_q        <= '0;
         wb_regwrite_q  <= 1'b0;
         cnt_q          <= '0;
      end else begin
         ex_rs1_q       <= ex_rs1_d;
         ex_rs2_q       <= ex_rs2_d;
         ex_rd_q        <= ex_rd_d;
         ex_regwrite_q  <= ex_regwrite_d;
         ex_memread_q   <= ex_memread_d;
         mem_rd_q       <= mem_rd_d;
         mem_regwrite_q <= mem_regwrite_d;
         wb_rd_q        <= wb_rd_d;
         wb_regwrite_q  <= wb_regwrite_d;
         cnt_q          <= cnt_d;
      end
   end

   assign ld_use_stall_o = ld_use_stall;
   assign ld_use_cnt_o   = cnt_q;

endmodule
